// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage and architectural register file: derives dstE/dstM, commits results,
// serves two bypassed read ports and tracks the sticky processor status and retired count.
module writeback_regfile #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              mem_error,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [2:0]        stat,
  output logic [CNT_W-1:0]  retired_count
);

  localparam logic [3:0]       REG_NONE = 4'hF;
  localparam logic [3:0]       REG_RSP  = 4'h4;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  stat_e             stat_q, stat_d;
  stat_e             cls_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [3:0]        dst_e_s, dst_m_s;
  logic              need_ra_s, need_rb_s;
  logic              accept_s, commit_s;

  assign wb_ready      = (stat_q == STAT_AOK);
  assign stat          = stat_q;
  assign retired_count = cnt_q;
  assign accept_s      = wb_valid & wb_ready;
  assign commit_s      = accept_s & (cls_s == STAT_AOK);

  always_comb begin
    dst_e_s = REG_NONE;
    dst_m_s = REG_NONE;
    case (icode)
      4'h2:                      dst_e_s = cnd ? rB : REG_NONE;
      4'h3, 4'h6:                dst_e_s = rB;
      4'h8, 4'h9, 4'hA, 4'hB:    dst_e_s = REG_RSP;
      default:                   dst_e_s = REG_NONE;
    endcase
    case (icode)
      4'h5, 4'hB: dst_m_s = rA;
      default:    dst_m_s = REG_NONE;
    endcase
  end

  always_comb begin
    need_ra_s = 1'b0;
    need_rb_s = 1'b0;
    case (icode)
      4'h2, 4'h6:             begin need_ra_s = 1'b1; need_rb_s = 1'b1; end
      4'h4, 4'h5, 4'hA, 4'hB: begin need_ra_s = 1'b1; need_rb_s = 1'b0; end
      4'h3:                   begin need_ra_s = 1'b0; need_rb_s = 1'b1; end
      default:                begin need_ra_s = 1'b0; need_rb_s = 1'b0; end
    endcase
  end

  // Fault priority: illegal icode, missing specifier, memory fault, halt.
  always_comb begin
    cls_s = STAT_AOK;
    if (icode > 4'hB) begin
      cls_s = STAT_INS;
    end else if ((need_ra_s && (rA == REG_NONE)) || (need_rb_s && (rB == REG_NONE))) begin
      cls_s = STAT_INS;
    end else if (mem_error) begin
      cls_s = STAT_ADR;
    end else if (icode == 4'h0) begin
      cls_s = STAT_HLT;
    end else begin
      cls_s = STAT_AOK;
    end
  end

  // dstM is written after dstE so that popq %rsp keeps the popped value.
  always_comb begin
    regs_d = regs_q;
    stat_d = stat_q;
    cnt_d  = cnt_q;
    if (commit_s) begin
      if (dst_e_s != REG_NONE) begin
        regs_d[dst_e_s] = valE;
      end else begin
        regs_d = regs_d;
      end
      if (dst_m_s != REG_NONE) begin
        regs_d[dst_m_s] = valM;
      end else begin
        regs_d = regs_d;
      end
      cnt_d = cnt_q + CNT_ONE;
    end else if (accept_s) begin
      stat_d = cls_s;
      cnt_d  = (cls_s == STAT_HLT) ? (cnt_q + CNT_ONE) : cnt_q;
    end else begin
      stat_d = stat_q;
    end
  end

  always_comb begin
    if (srcA == REG_NONE) begin
      valA = {DATA_W{1'b0}};
    end else if (commit_s && (srcA == dst_m_s)) begin
      valA = valM;
    end else if (commit_s && (srcA == dst_e_s)) begin
      valA = valE;
    end else begin
      valA = regs_q[srcA];
    end
  end

  always_comb begin
    if (srcB == REG_NONE) begin
      valB = {DATA_W{1'b0}};
    end else if (commit_s && (srcB == dst_m_s)) begin
      valB = valM;
    end else if (commit_s && (srcB == dst_e_s)) begin
      valB = valE;
    end else begin
      valB = regs_q[srcB];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      stat_q <= STAT_AOK;
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      regs_q <= regs_d;
      stat_q <= stat_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: hand-computed expectations for commits, bypass,
// faults, counter wrap (4-bit counter) and asynchronous reset.
module tb_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  icode, rA, rB, srcA, srcB;
  logic        cnd, mem_error;
  logic [63:0] valE, valM, valA, valB;
  logic [2:0]  stat;
  logic [3:0]  retired_count;

  int n_vec;
  int n_miss;

  writeback_regfile #(.DATA_W(64), .NREG(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .icode(icode), .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM),
    .mem_error(mem_error), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .stat(stat), .retired_count(retired_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one retiring instruction.
  task automatic issue(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm,
                       input logic me);
    wb_valid  = 1'b1;
    icode     = ic;
    rA        = ra;
    rB        = rb;
    cnd       = c;
    valE      = ve;
    valM      = vm;
    mem_error = me;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    wb_valid  = 1'b0;
    mem_error = 1'b0;
    cnd       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
    cnd = 1'b0; valE = 64'h0; valM = 64'h0; mem_error = 1'b0;
    srcA = 4'hF; srcB = 4'hF;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    chk("reset_stat",  {61'd0, stat}, 64'd1);
    chk("reset_ready", {63'd0, wb_ready}, 64'd1);
    chk("reset_count", {60'd0, retired_count}, 64'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      srcA = i[3:0];
      #1 chk("reset_reg", valA, 64'd0);
    end

    // irmovq 0x1234 -> %rdx, bypass then storage
    @(negedge clk);
    issue(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b0);
    srcA = 4'h2;
    #1 chk("irmov_bypass", valA, 64'h1234);
    step();
    #1 chk("irmov_store", valA, 64'h1234);
    chk("irmov_count", {60'd0, retired_count}, 64'd1);

    // cmovXX not taken, then taken
    issue(4'h2, 4'h1, 4'h5, 1'b0, 64'h7, 64'h0, 1'b0);
    srcB = 4'h5;
    #1 chk("cmov_nt_bypass", valB, 64'h0);
    step();
    #1 chk("cmov_nt_store", valB, 64'h0);
    issue(4'h2, 4'h1, 4'h5, 1'b1, 64'h7, 64'h0, 1'b0);
    step();
    #1 chk("cmov_t_store", valB, 64'h7);
    chk("cmov_count", {60'd0, retired_count}, 64'd3);

    // popq %rsp: valM wins over valE on the same destination
    issue(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hBEEF, 1'b0);
    srcA = 4'h4;
    #1 chk("poprsp_bypass", valA, 64'hBEEF);
    step();
    #1 chk("poprsp_store", valA, 64'hBEEF);

    // popq %rbx: two writes on one edge
    issue(4'hB, 4'h3, 4'hF, 1'b0, 64'h110, 64'hCAFE, 1'b0);
    srcA = 4'h3; srcB = 4'h4;
    #1 chk("poprbx_bypA", valA, 64'hCAFE);
    chk("poprbx_bypB", valB, 64'h110);
    step();
    #1 chk("poprbx_r3", valA, 64'hCAFE);
    chk("poprbx_r4", valB, 64'h110);
    chk("poprbx_count", {60'd0, retired_count}, 64'd5);

    // 11 nops take the 4-bit counter from 5 through 15 to 0
    for (int i = 0; i < 10; i++) begin
      issue(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
      step();
    end
    chk("count_15", {60'd0, retired_count}, 64'd15);
    issue(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    step();
    chk("count_wrap", {60'd0, retired_count}, 64'd0);

    // reset in the middle of a write burst
    issue(4'h3, 4'hF, 4'h6, 1'b0, 64'h55, 64'h0, 1'b0);
    step();
    issue(4'h3, 4'hF, 4'h6, 1'b0, 64'h66, 64'h0, 1'b0);
    #2 rst_n = 1'b0;
    srcA = 4'h2;
    #1 chk("midrst_stat", {61'd0, stat}, 64'd1);
    chk("midrst_count", {60'd0, retired_count}, 64'd0);
    chk("midrst_r2", valA, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; wb_valid = 1'b0;
    srcA = 4'h6;
    #1 chk("midrst_r6", valA, 64'h0);

    // opq with rA==F -> INS, no writes, later instructions ignored
    @(negedge clk);
    issue(4'h6, 4'hF, 4'h1, 1'b0, 64'h9, 64'h0, 1'b0);
    srcA = 4'h1;
    #1 chk("ins_nobypass", valA, 64'h0);
    step();
    #1 chk("ins_stat", {61'd0, stat}, 64'd4);
    chk("ins_ready", {63'd0, wb_ready}, 64'd0);
    chk("ins_r1", valA, 64'h0);
    chk("ins_count", {60'd0, retired_count}, 64'd0);
    issue(4'h3, 4'hF, 4'h3, 1'b0, 64'h77, 64'h0, 1'b0);
    srcA = 4'h3;
    #1 chk("ins_ign_byp", valA, 64'h0);
    step();
    #1 chk("ins_ign_r3", valA, 64'h0);
    chk("ins_ign_count", {60'd0, retired_count}, 64'd0);
    chk("ins_sticky", {61'd0, stat}, 64'd4);

    // mrmovq with memory fault -> ADR
    do_reset();
    issue(4'h5, 4'h2, 4'h3, 1'b0, 64'h40, 64'h99, 1'b1);
    step();
    srcA = 4'h2;
    #1 chk("adr_stat", {61'd0, stat}, 64'd3);
    chk("adr_r2", valA, 64'h0);
    chk("adr_count", {60'd0, retired_count}, 64'd0);

    // halt retires and counts
    do_reset();
    issue(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    step();
    chk("hlt_stat", {61'd0, stat}, 64'd2);
    chk("hlt_count", {60'd0, retired_count}, 64'd1);
    chk("hlt_ready", {63'd0, wb_ready}, 64'd0);

    // icode above B -> INS, even with a memory fault pending
    do_reset();
    issue(4'hC, 4'h1, 4'h2, 1'b0, 64'h0, 64'h0, 1'b1);
    step();
    chk("badicode_stat", {61'd0, stat}, 64'd4);
    chk("badicode_count", {60'd0, retired_count}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
